bram_port_master: RTL and testbench

BRAM_PORT_MASTER -- requirements
Module: bram_port_master

---
 rtl/bram_port_master.sv | 135 +++++++++++++
 tb/tb_bram_port_master.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_master.sv
// bram_port_master: valid/ready request front-end driving one BRAM port, with a credit-limited read-response FIFO.
// Optional macro BRAM_PORT_MASTER_STATS_EN adds stat_reads / stat_writes request counters.
module bram_port_master #(
    parameter int ADDR_WIDTH = 7,
    parameter int RESP_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic                  BRAM_CLKA,
    output logic                  BRAM_RSTA,
    output logic                  BRAM_ENA,
    output logic [3:0]            BRAM_WENA,
    output logic [ADDR_WIDTH-1:0] BRAM_AddrA,
    output logic [31:0]           BRAM_DoutA,
    input  logic [31:0]           BRAM_DinA
`ifdef BRAM_PORT_MASTER_STATS_EN
    ,
    output logic [31:0]           stat_reads,
    output logic [31:0]           stat_writes
`endif
);

    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;

    // Handshakes: a beat transfers on a CLK edge where valid && ready; ready never looks at valid.
    logic                 ready_q;
    logic                 rd_s1;
    logic                 rd_s2;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_n;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [31:0]          fifo_mem [RESP_DEPTH];
    logic                 req_fire;
    logic                 resp_fire;
    logic                 enq;
    logic                 rd_s1_n;
    logic [SUM_W-1:0]     credits_n;
    logic                 ready_n;

    always_comb begin
        req_fire  = req_valid && ready_q;
        resp_fire = resp_valid && resp_ready;
        enq       = rd_s2;
        rd_s1_n   = req_fire && !req_write;
        count_n   = count_q + CNT_W'(enq) - CNT_W'(resp_fire);
        // Credits for the next cycle: queued entries plus reads still in the BRAM pipeline.
        credits_n = SUM_W'(count_n) + SUM_W'(rd_s1_n) + SUM_W'(rd_s1);
        ready_n   = credits_n < SUM_W'(RESP_DEPTH);
    end

    assign req_ready  = ready_q;
    assign resp_valid = (count_q != '0);
    assign resp_data  = fifo_mem[rd_ptr];
    assign BRAM_CLKA  = CLK;
    assign BRAM_RSTA  = 1'b0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ready_q <= 1'b0;
            rd_s1   <= 1'b0;
            rd_s2   <= 1'b0;
            count_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            ready_q <= ready_n;
            rd_s1   <= rd_s1_n;
            rd_s2   <= rd_s1;
            count_q <= count_n;
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (resp_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            BRAM_ENA   <= 1'b0;
            BRAM_WENA  <= 4'h0;
            BRAM_AddrA <= '0;
            BRAM_DoutA <= '0;
        end else begin
            BRAM_ENA  <= req_fire;
            BRAM_WENA <= (req_fire && req_write) ? 4'hF : 4'h0;
            if (req_fire) begin
                BRAM_AddrA <= req_addr;
                BRAM_DoutA <= req_data;
            end
        end
    end

    // Storage needs no reset: entries are only visible while count_q covers them.
    always_ff @(posedge CLK) begin
        if (enq) begin
            fifo_mem[wr_ptr] <= BRAM_DinA;
        end
    end

`ifdef BRAM_PORT_MASTER_STATS_EN
    logic [31:0] stat_reads_q;
    logic [31:0] stat_writes_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stat_reads_q  <= 32'h0;
            stat_writes_q <= 32'h0;
        end else begin
            if (req_fire && !req_write) begin
                stat_reads_q <= stat_reads_q + 32'd1;
            end
            if (req_fire && req_write) begin
                stat_writes_q <= stat_writes_q + 32'd1;
            end
        end
    end

    assign stat_reads  = stat_reads_q;
    assign stat_writes = stat_writes_q;
`endif

endmodule

// File: tb/tb_bram_port_master.sv
// Testbench for bram_port_master: BRAM behavioural model, reference memory plus expected-response queue.
// Build with +define+BRAM_PORT_MASTER_STATS_EN to also exercise the statistics counters.
module tb_bram_port_master;

    localparam int AW    = 7;
    localparam int DEPTH = 4;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b1;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_data;
    logic          BRAM_CLKA;
    logic          BRAM_RSTA;
    logic          BRAM_ENA;
    logic [3:0]    BRAM_WENA;
    logic [AW-1:0] BRAM_AddrA;
    logic [31:0]   BRAM_DoutA;
    logic [31:0]   BRAM_DinA = 32'h0;
`ifdef BRAM_PORT_MASTER_STATS_EN
    logic [31:0]   stat_reads;
    logic [31:0]   stat_writes;
`endif

    always #5 CLK = ~CLK;

    bram_port_master #(.ADDR_WIDTH(AW), .RESP_DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .BRAM_CLKA  (BRAM_CLKA),
        .BRAM_RSTA  (BRAM_RSTA),
        .BRAM_ENA   (BRAM_ENA),
        .BRAM_WENA  (BRAM_WENA),
        .BRAM_AddrA (BRAM_AddrA),
        .BRAM_DoutA (BRAM_DoutA),
        .BRAM_DinA  (BRAM_DinA)
`ifdef BRAM_PORT_MASTER_STATS_EN
        ,
        .stat_reads (stat_reads),
        .stat_writes(stat_writes)
`endif
    );

    // Registered-output BRAM: data for a sampled address appears after that edge.
    logic [31:0] bram_mem [1<<AW] = '{default: 32'h0};
    always @(posedge BRAM_CLKA) begin
        if (BRAM_ENA) begin
            if (BRAM_WENA == 4'hF) bram_mem[BRAM_AddrA] <= BRAM_DoutA;
            BRAM_DinA <= bram_mem[BRAM_AddrA];
        end
    end

    int          n_checks = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          acc_total = 0;
    int          ref_reads = 0;
    int          ref_writes = 0;
    logic [31:0] exp_q[$];
    int          resp_cyc[$];
    logic [31:0] ref_mem [1<<AW] = '{default: 32'h0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: observe handshakes at the falling edge, then advance past the rising edge.
    task automatic tick();
        @(negedge CLK);
        if (!RST_N) begin
            exp_q.delete();
            ref_reads  = 0;
            ref_writes = 0;
        end else begin
            if (resp_valid && resp_ready) begin
                chk("resp_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("resp_data", resp_data, exp_q.pop_front());
                resp_cyc.push_back(cyc);
            end
            if (req_valid && req_ready) begin
                acc_total++;
                if (req_write) begin
                    ref_mem[req_addr] = req_data;
                    ref_writes++;
                end else begin
                    exp_q.push_back(ref_mem[req_addr]);
                    ref_reads++;
                end
            end
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [31:0] d);
        int waited;
        waited    = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_data  = d;
        while (!req_ready && waited < 50) begin
            tick();
            waited++;
        end
        chk("issue_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n          = 0;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        while ((exp_q.size() != 0 || resp_valid) && n < 60) begin
            tick();
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int acc0;
        int seen;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_data   = 32'h0;
        resp_ready = 1'b0;

        // Reset values
        #1 RST_N = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_ena", 32'(BRAM_ENA), 32'd0);
        chk("rst_wena", 32'(BRAM_WENA), 32'd0);
        chk("rst_addr", 32'(BRAM_AddrA), 32'd0);
        chk("rst_dout", BRAM_DoutA, 32'd0);
        chk("rsta_const", 32'(BRAM_RSTA), 32'd0);
        tick();
        tick();
        chk("rst_hold_ready", 32'(req_ready), 32'd0);
        RST_N = 1'b1;
        chk("release_ready_low", 32'(req_ready), 32'd0);
        tick();
        chk("release_ready_rise", 32'(req_ready), 32'd1);

        // Write then read the same address, checking port pulses and latency
        issue(1'b1, 7'd5, 32'hDEADBEEF);
        chk("wr_ena", 32'(BRAM_ENA), 32'd1);
        chk("wr_wena", 32'(BRAM_WENA), 32'hF);
        chk("wr_addr", 32'(BRAM_AddrA), 32'd5);
        chk("wr_dout", BRAM_DoutA, 32'hDEADBEEF);
        tick();
        chk("idle_ena", 32'(BRAM_ENA), 32'd0);
        chk("idle_wena", 32'(BRAM_WENA), 32'd0);
        chk("idle_addr_hold", 32'(BRAM_AddrA), 32'd5);
        chk("idle_dout_hold", BRAM_DoutA, 32'hDEADBEEF);
        issue(1'b0, 7'd5, 32'h0);
        chk("rd_ena", 32'(BRAM_ENA), 32'd1);
        chk("rd_wena", 32'(BRAM_WENA), 32'd0);
        chk("rd_lat0", 32'(resp_valid), 32'd0);
        tick();
        chk("rd_lat1", 32'(resp_valid), 32'd0);
        tick();
        chk("rd_lat2", 32'(resp_valid), 32'd1);
        chk("rd_lat2_data", resp_data, 32'hDEADBEEF);
        resp_ready = 1'b1;
        tick();
        chk("rd_dequeued", 32'(resp_valid), 32'd0);

        // Preload 0..7 with 100+i, then back-to-back reads
        for (int i = 0; i < 8; i++) issue(1'b1, AW'(i), 32'(100 + i));
        drain();
        resp_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = AW'(i);
            chk("b2b_ready", 32'(req_ready), 32'd1);
            tick();
        end
        drain();
        chk("b2b_count", 32'(resp_cyc.size()), 32'd8);
        for (int i = 1; i < resp_cyc.size(); i++)
            chk("b2b_consecutive", 32'(resp_cyc[i] - resp_cyc[i-1]), 32'd1);

        // Credit limit with responses blocked
        resp_ready = 1'b0;
        acc0       = acc_total;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            req_addr = AW'($urandom_range(0, 7));
            tick();
        end
        chk("credit_accepts", 32'(acc_total - acc0), 32'd4);
        chk("credit_ready_low", 32'(req_ready), 32'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        acc0 = acc_total;
        for (int i = 0; i < 6; i++) tick();
        chk("credit_one_more", 32'(acc_total - acc0), 32'd1);
        chk("credit_ready_low2", 32'(req_ready), 32'd0);
        drain();

        // Reset with 2 queued and 2 in flight
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_addr = AW'(i);
            tick();
        end
        req_valid = 1'b0;
        chk("pre_reset_valid", 32'(resp_valid), 32'd1);
        RST_N = 1'b0;
        #1;
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_ena", 32'(BRAM_ENA), 32'd0);
        tick();
        tick();
        RST_N = 1'b1;
        tick();
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        resp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (resp_valid) seen++;
            tick();
        end
        chk("post_rst_no_resp", 32'(seen), 32'd0);

        // Random mix with random backpressure
        for (int i = 0; i < 400; i++) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            req_write  = 1'($urandom_range(0, 1));
            req_addr   = AW'($urandom_range(0, (1 << AW) - 1));
            req_data   = $urandom;
            resp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // Full throughput with resp_ready held high
        for (int i = 0; i < 100; i++) begin
            req_valid = 1'b1;
            req_write = 1'($urandom_range(0, 1));
            req_addr  = AW'($urandom_range(0, 15));
            req_data  = $urandom;
            chk("thru_ready", 32'(req_ready), 32'd1);
            tick();
        end
        drain();
        chk("end_resp_valid", 32'(resp_valid), 32'd0);

`ifdef BRAM_PORT_MASTER_STATS_EN
        chk("stat_reads", stat_reads, 32'(ref_reads));
        chk("stat_writes", stat_writes, 32'(ref_writes));
        acc0 = ref_writes;
        force dut.stat_reads_q = 32'hFFFFFFFF;
        #1;
        release dut.stat_reads_q;
        issue(1'b0, 7'd1, 32'h0);
        chk("stat_reads_wrap", stat_reads, 32'h0);
        chk("stat_writes_hold", stat_writes, 32'(acc0));
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
